// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_WIDTH = 4;

    // Width needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// rtl/nibble_serial_adder_cla4.sv - CarryLookaheadAdder4 slice: 4-bit carry-lookahead adder
import nibble_serial_adder_pkg::*;

module nibble_serial_adder_cla4 (
    input  logic [NIBBLE_WIDTH-1:0] i_a,
    input  logic [NIBBLE_WIDTH-1:0] i_b,
    input  logic                    i_cin,
    output logic [NIBBLE_WIDTH-1:0] o_sum,
    output logic                    o_cout,
    output logic                    o_pg,
    output logic                    o_gg
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Every internal carry is a flat sum of products of p/g and cin.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_pg = &w_p;
    assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign o_sum  = w_p ^ w_c;
    assign o_cout = o_gg | (o_pg & i_cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder time-sharing one 4-bit CLA slice, LS nibble first
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
import nibble_serial_adder_pkg::*;

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InputValid,
    output logic             InputReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputCarry,
    output logic             OutputValid,
    input  logic             OutputReady,
    output logic [WIDTH-1:0] Output,
    output logic             OutputCarry
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             OutputOverflow
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_WIDTH;
    localparam int CNT_W   = clog2(NIBBLES);

    state_t            r_state;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [WIDTH-1:0]  r_result;
    logic              r_carry;
    logic [CNT_W-1:0]  r_count;

    logic [NIBBLE_WIDTH-1:0] w_slice_sum;
    logic                    w_slice_cout;
    logic                    w_last_nibble;

    nibble_serial_adder_cla4 u_slice (
        .i_a    (r_op_a[NIBBLE_WIDTH-1:0]),
        .i_b    (r_op_b[NIBBLE_WIDTH-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout),
        .o_pg   (),
        .o_gg   ()
    );

    assign w_last_nibble = (r_count == CNT_W'(NIBBLES - 1));

    // Handshake flags come straight from the state register.
    assign InputReady  = (r_state == ST_IDLE);
    assign OutputValid = (r_state == ST_DONE);
    assign Output      = r_result;
    assign OutputCarry = r_carry;

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic r_sign_a;
    logic r_sign_b;
    logic r_overflow;

    assign OutputOverflow = r_overflow;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == ST_IDLE && InputValid) begin
            r_sign_a <= InputA[WIDTH-1];
            r_sign_b <= InputB[WIDTH-1];
        end else if (r_state == ST_RUN && w_last_nibble) begin
            // The top nibble's MSB is the result sign bit.
            r_overflow <= (r_sign_a == r_sign_b) && (w_slice_sum[NIBBLE_WIDTH-1] != r_sign_a);
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (InputValid) begin
                        r_op_a  <= InputA;
                        r_op_b  <= InputB;
                        r_carry <= InputCarry;
                        r_count <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result <= {w_slice_sum, r_result[WIDTH-1:NIBBLE_WIDTH]};
                    r_carry  <= w_slice_cout;
                    r_op_a   <= r_op_a >> NIBBLE_WIDTH;
                    r_op_b   <= r_op_b >> NIBBLE_WIDTH;
                    r_count  <= r_count + CNT_W'(1);
                    if (w_last_nibble) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OutputReady) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (WIDTH=16)
module tb_nibble_serial_adder;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InputValid;
    logic         InputReady;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic         InputCarry;
    logic         OutputValid;
    logic         OutputReady;
    logic [W-1:0] Output;
    logic         OutputCarry;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic         OutputOverflow;
`endif

    int   tests = 0;
    int   fails = 0;
    vec_t sb_q[$];
    vec_t vecs[8];

    always #5 Clock = ~Clock;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InputValid     (InputValid),
        .InputReady     (InputReady),
        .InputA         (InputA),
        .InputB         (InputB),
        .InputCarry     (InputCarry),
        .OutputValid    (OutputValid),
        .OutputReady    (OutputReady),
        .Output         (Output),
        .OutputCarry    (OutputCarry)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        ,
        .OutputOverflow (OutputOverflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        vec_t v;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sum  = full[W-1:0];
        v.cout = full[W];
        v.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return v;
    endfunction

    task automatic compare_out(input string tag, input vec_t e);
        check({tag, "_sum"}, Output, e.sum);
        check({tag, "_carry"}, OutputCarry, e.cout);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        check({tag, "_ovf"}, OutputOverflow, e.ovf);
`endif
    endtask

    task automatic send(input vec_t v);
        int n;
        n = 0;
        while (!InputReady && n < 50) begin
            step();
            n++;
        end
        check("ready_before_accept", InputReady, 1);
        InputA     = v.a;
        InputB     = v.b;
        InputCarry = v.cin;
        InputValid = 1'b1;
        sb_q.push_back(v);
        step();
        InputValid = 1'b0;
    endtask

    // Waits for the result, optionally stalls in DONE and pokes junk operands while busy.
    task automatic receive(input int hold, input bit poke);
        vec_t e;
        int   n;
        n = 0;
        while (!OutputValid && n < 20) begin
            check("ready_low_busy", InputReady, 0);
            if (poke && n == 1) begin
                InputValid = 1'b1;
                InputA     = 16'hDEAD;
                InputB     = 16'hBEEF;
                InputCarry = 1'b1;
            end else begin
                InputValid = 1'b0;
            end
            step();
            n++;
        end
        InputValid = 1'b0;
        check("latency", n, NIBBLES);
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb_q.pop_front();
        compare_out("result", e);
        for (int i = 0; i < hold; i++) begin
            InputValid = poke && (i == 0);
            InputA     = 16'h1111;
            InputB     = 16'h2222;
            step();
            InputValid = 1'b0;
            check("hold_valid", OutputValid, 1);
            compare_out("hold", e);
        end
        OutputReady = 1'b1;
        step();
        OutputReady = 1'b0;
        check("valid_drop", OutputValid, 0);
        check("ready_return", InputReady, 1);
    endtask

    initial begin
        vec_t bb[6];
        vec_t e;
        int   idx;
        int   got;
        int   last;
        int   cyc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[7] = '{16'h8765, 16'h9ABC, 1'b0, 16'h2221, 1'b1, 1'b1};

        Reset       = 1'b1;
        InputValid  = 1'b0;
        OutputReady = 1'b0;
        InputA      = '0;
        InputB      = '0;
        InputCarry  = 1'b0;
        step();
        step();
        Reset = 1'b0;
        check("reset_ready", InputReady, 1);
        check("reset_valid", OutputValid, 0);
        check("reset_out", Output, 0);
        check("reset_carry", OutputCarry, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        check("reset_ovf", OutputOverflow, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            receive(0, 1'b0);
        end

        // Stall in DONE while junk operands are offered during RUN and DONE.
        send(vecs[6]);
        receive(5, 1'b1);
        send(vecs[0]);
        receive(0, 1'b0);

        // Reset after two RUN edges discards the operation.
        send(vecs[7]);
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        void'(sb_q.pop_back());
        check("midreset_valid", OutputValid, 0);
        check("midreset_out", Output, 0);
        check("midreset_carry", OutputCarry, 0);
        check("midreset_ready", InputReady, 1);
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        check("midreset_ovf", OutputOverflow, 0);
`endif
        send(vecs[5]);
        receive(0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            send(mk(16'($urandom), 16'($urandom), 1'($urandom)));
            receive(i, 1'b0);
        end

        // Back-to-back with both handshakes tied high.
        for (int i = 0; i < 6; i++) begin
            bb[i] = mk(16'($urandom), 16'($urandom), 1'($urandom));
        end
        InputValid  = 1'b1;
        OutputReady = 1'b1;
        idx  = 0;
        got  = 0;
        last = -1;
        cyc  = 0;
        while (got < 6 && cyc < 200) begin
            if (OutputValid) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    compare_out("b2b", e);
                end
                if (last >= 0) begin
                    check("b2b_interval", cyc - last, NIBBLES + 2);
                end
                last = cyc;
                got++;
            end
            if (InputReady && idx < 6) begin
                InputA     = bb[idx].a;
                InputB     = bb[idx].b;
                InputCarry = bb[idx].cin;
                sb_q.push_back(bb[idx]);
                idx++;
            end
            step();
            cyc++;
        end
        InputValid  = 1'b0;
        OutputReady = 1'b0;
        check("b2b_count", got, 6);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
